// File: rtl/wb_traffic_gen.sv
// Wishbone B3 initiator: writes an address-derived burst, reads it back,
// compares every beat and reports pass/fail with a saturating error count.
module wb_traffic_gen #(
  parameter int          APP_AW  = 26,
  parameter int          DW      = 32,
  parameter int          BW      = 4,
  parameter logic [31:0] SEED    = 32'hA5A5_0000,
  parameter int          TIMEOUT = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic [APP_AW-1:0] base_addr,
  input  logic [7:0]        burst_len,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [BW-1:0]     wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic              timeout_err
);

  localparam int AB    = $clog2(BW);
  localparam int WDT_W = $clog2(TIMEOUT + 1);
  localparam logic [WDT_W-1:0]  WDT_LOAD   = WDT_W'(TIMEOUT - 1);
  localparam logic [APP_AW-1:0] ALIGN_MASK = ~(APP_AW'(BW - 1));
  localparam logic [APP_AW-1:0] ADDR_STEP  = APP_AW'(BW);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_WR   | write burst in progress
  // S_GAP  | one idle bus cycle between phases
  // S_RD   | read-back and compare burst
  // S_FIN  | done pulse, result valid
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_GAP  = 3'd2,
    S_RD   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [APP_AW-1:0] r_base;
  logic [APP_AW-1:0] r_addr;
  logic [7:0]        r_beat;
  logic [7:0]        r_last_idx;
  logic [WDT_W-1:0]  r_wdt;
  logic [15:0]       r_err_count;
  logic              r_pass;
  logic              r_timeout_err;

  logic              w_cyc;
  logic              w_we;
  logic              w_done;
  logic              w_active;
  logic              w_ack;
  logic              w_last;
  logic              w_tmo;
  logic              w_mismatch;
  logic [DW-1:0]     w_pattern;
  logic [15:0]       w_err_next;

  assign w_active   = (r_state == S_WR) || (r_state == S_RD);
  assign w_ack      = w_active && wb_ack_i;
  assign w_last     = (r_beat == r_last_idx);
  // Watchdog terminal count: no ack after TIMEOUT strobed cycles.
  assign w_tmo      = w_active && !wb_ack_i && (r_wdt == '0);
  assign w_pattern  = DW'(r_addr >> AB) ^ DW'(SEED);
  assign w_mismatch = (r_state == S_RD) && wb_ack_i && (wb_dat_i != w_pattern);

  always_comb begin
    w_err_next = r_err_count;
    if (w_mismatch && (r_err_count != 16'hFFFF)) begin
      w_err_next = r_err_count + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_cyc  = 1'b0;
    w_we   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_WR;
      end
      S_WR: begin
        w_cyc = 1'b1;
        w_we  = 1'b1;
        if (w_tmo) begin
          w_next = S_FIN;
        end else if (w_ack && w_last) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        w_next = S_RD;
      end
      S_RD: begin
        w_cyc = 1'b1;
        if (w_tmo || (w_ack && w_last)) w_next = S_FIN;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_base        <= '0;
      r_addr        <= '0;
      r_beat        <= '0;
      r_last_idx    <= '0;
      r_wdt         <= WDT_LOAD;
      r_err_count   <= '0;
      r_pass        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (!w_active || wb_ack_i) begin
        r_wdt <= WDT_LOAD;
      end else if (r_wdt != '0) begin
        r_wdt <= r_wdt - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base        <= base_addr & ALIGN_MASK;
            r_addr        <= base_addr & ALIGN_MASK;
            r_beat        <= '0;
            // burst_len of 0 wraps to last index 255, i.e. 256 beats.
            r_last_idx    <= burst_len - 8'd1;
            r_err_count   <= '0;
            r_pass        <= 1'b0;
            r_timeout_err <= 1'b0;
          end
        end
        S_WR: begin
          if (w_tmo) begin
            r_timeout_err <= 1'b1;
            r_pass        <= 1'b0;
          end else if (w_ack) begin
            r_addr <= r_addr + ADDR_STEP;
            r_beat <= r_beat + 8'd1;
          end
        end
        S_GAP: begin
          r_addr <= r_base;
          r_beat <= '0;
        end
        S_RD: begin
          if (w_tmo) begin
            r_timeout_err <= 1'b1;
            r_pass        <= 1'b0;
          end else if (w_ack) begin
            r_err_count <= w_err_next;
            r_addr      <= r_addr + ADDR_STEP;
            r_beat      <= r_beat + 8'd1;
            if (w_last) r_pass <= (w_err_next == 16'd0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign wb_cyc_o    = w_cyc;
  assign wb_stb_o    = w_cyc;
  assign wb_we_o     = w_we;
  assign wb_addr_o   = w_cyc ? r_addr : '0;
  assign wb_dat_o    = w_we ? w_pattern : '0;
  assign wb_sel_o    = w_cyc ? '1 : '0;
  assign wb_cti_o    = !w_cyc ? 3'b000 : (w_last ? 3'b111 : 3'b010);
  assign busy        = (r_state != S_IDLE);
  assign done        = w_done;
  assign pass        = r_pass;
  assign err_count   = r_err_count;
  assign timeout_err = r_timeout_err;

endmodule

// File: doc/wb_traffic_gen.md
# wb_traffic_gen

Synthesizable Wishbone B3 initiator that drives the application port of `sdrc_top` on behalf of on-chip logic or a bring-up harness. On a start pulse it writes an incrementing burst of address-derived data to the SDRAM controller, reads the same range back, compares every beat and reports pass/fail with an error count. It is the initiator counterpart to the controller's Wishbone responder and is the hardware equivalent of the bench write/read-compare sequence.

## Interface
- APP_AW, 26, Wishbone byte-address width
- DW, 32, Wishbone data width
- BW, 4, byte lanes (DW/8)
- SEED, 32'hA5A5_0000, XOR seed for the data pattern
- TIMEOUT, 1024, max cycles to wait for `wb_ack_i` per beat

- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  synchronous active-high reset
- start  in  1  one-cycle request, sampled only in IDLE
- base_addr  in  APP_AW  byte start address, must be BW-aligned (low bits ignored)
- burst_len  in  8  beats per phase; 0 means 256
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  1 write, 0 read
- wb_addr_o  out  APP_AW  byte address
- wb_dat_o  out  DW  write data
- wb_sel_o  out  BW  byte enables
- wb_cti_o  out  3  cycle type
- wb_ack_i  in  1  responder acknowledge
- wb_dat_i  in  DW  read data
- busy  out  1  high from start accept until done
- done  out  1  one-cycle completion pulse
- pass  out  1  result of last run, valid from done until next start
- err_count  out  16  mismatching beats of last run, saturates at 16'hFFFF
- timeout_err  out  1  last run aborted by watchdog

## Operation
- States: IDLE, WR, GAP, RD, FIN.
- IDLE: on `start`, latch `base_addr` (low log2(BW) bits forced 0) and beat count N (burst_len, 0→256); clear err_count, pass, timeout_err; go WR.
- WR: cyc=stb=we=1, sel=all ones. Beat i address = base + i*BW; data = (address >> log2(BW)) XOR SEED, truncated to DW. cti=3'b010 for beats 0..N-2, 3'b111 on beat N-1 (N=1: 3'b111 only). Address/data/cti advance on the edge where ack=1. After last ack → GAP.
- GAP: cyc=stb=0 for exactly one cycle → RD.
- RD: as WR with we=0, wb_dat_o don't-care (drive 0). On each ack compare wb_dat_i with expected pattern; mismatch increments err_count (saturating). After last ack → FIN.
- FIN: one cycle; done=1, pass=(err_count==0 incl. final beat)&&!timeout_err → IDLE.
- Watchdog: counter reset on every ack and at phase entry; if it reaches TIMEOUT while stb=1, drop cyc/stb, set timeout_err, go FIN (pass=0).
- Address arithmetic modulo 2^APP_AW: wraps silently past top of space.
- `start` outside IDLE ignored.

## Timing
- Reset values: cyc, stb, we, done, pass, busy, timeout_err = 0; addr, dat, sel, cti, err_count = 0; state IDLE.
- Reset mid-burst: cyc/stb low on the edge after wb_rst_i sampled high; no partial result reported.
- start sampled at edge k → cyc/stb/busy high from k+1.
- Signals held stable while stb=1 and ack=0; back-to-back acks give one beat per cycle.
- Last write ack at edge m → cyc low for cycle m+1, read beat 0 presented at m+2.
- Last read ack at edge r → cyc/stb low and done=1 during cycle r+1; busy low at r+2.
- Compare uses wb_dat_i sampled on the ack edge; err_count reflects it one cycle later, before done.

## Test plan
- base_addr=0x100, burst_len=4, ideal responder (ack one cycle after stb) → writes 0x100..0x10C with data 0xA5A50040..0xA5A50043, cti 010,010,010,111; one-cycle gap; reads; done with pass=1, err_count=0.
- Same run, responder flips bit 0 of read beat 2 → err_count=1, pass=0.
- burst_len=0, base 0x3FFFFF0 (APP_AW=26) → 256 beats per phase, address wraps to 0x0000000 after 0x3FFFFFC, pass=1.
- Responder stalls ack forever on write beat 1, TIMEOUT=16 → cyc drops 16 cycles after last activity, timeout_err=1, done pulse, pass=0.
- Assert wb_rst_i during read beat 3 → cyc/stb=0 next cycle, busy=0, done never pulses; subsequent start runs clean.
- Pulse start while busy and burst_len=1 run → second start ignored; single-beat cti=111 each phase.
